// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg - shared mode constants and parameter helpers for counters
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

  localparam int unsigned COUNT_WRAP     = 0;
  localparam int unsigned COUNT_SATURATE = 1;

  localparam int unsigned PRESCALE_MAX = 65535;

  // Ceiling log2; returns 0 for v <= 1, callers guard that case.
  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned     r;
    longint unsigned x;
    r = 0;
    x = (v > 0) ? v - 64'd1 : 64'd0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic bit width_legal(input int unsigned w);
    return (w >= 1) && (w <= 32);
  endfunction

  function automatic bit max_count_legal(input int unsigned w, input longint unsigned m);
    return (m >= 64'd1) && (m <= ((64'd1 << w) - 64'd1));
  endfunction

  function automatic bit prescale_legal(input int unsigned p);
    return (p >= 1) && (p <= PRESCALE_MAX);
  endfunction

endpackage : counter_pkg

`default_nettype wire

// File: rtl/counter_prescaler.sv
// ---------------------------------------------------------------------------
// counter_prescaler - divides enabled cycles down to one tick per PRESCALE
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module counter_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  if (!prescale_legal(PRESCALE)) begin : g_bad_prescale
    $error("counter_prescaler: PRESCALE must be in 1..65535");
  end

  if (PRESCALE <= 1) begin : g_bypass
    // No divider state at all: every enabled cycle is a tick.
    logic w_unused;
    assign w_unused = reset ^ clear;
    assign tick     = enable;
  end else begin : g_divide
    localparam int unsigned          c_PS_W = clog2(PRESCALE);
    localparam logic [c_PS_W-1:0]    c_LAST = c_PS_W'(PRESCALE - 1);

    logic [c_PS_W-1:0] presc_q;
    logic [c_PS_W-1:0] presc_d;

    assign tick = enable && (presc_q == c_LAST);

    always_comb begin
      presc_d = presc_q;
      if (clear) begin
        presc_d = '0;
      end else if (enable) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
      end
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_d;
      end
    end
  end

endmodule : counter_prescaler

`default_nettype wire

// File: rtl/up_down_counter_n.sv
// ---------------------------------------------------------------------------
// up_down_counter_n - parametrised up/down counter with load, wrap/saturate
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module up_down_counter_n
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = 4,
  parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     PRESCALE  = 1,
  parameter int unsigned     SATURATE  = COUNT_WRAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             overflow,
  output logic             at_zero,
  output logic             at_max
);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("up_down_counter_n: WIDTH must be in 1..32");
  end

  if (!max_count_legal(WIDTH, MAX_COUNT)) begin : g_bad_max
    $error("up_down_counter_n: MAX_COUNT must be in 1..2**WIDTH-1");
  end

  // Limits are compared one bit wider so MAX_COUNT = 2**WIDTH-1 stays exact.
  localparam logic [WIDTH:0]   c_MAX_EXT = MAX_COUNT[WIDTH:0];
  localparam logic [WIDTH-1:0] c_MAX     = MAX_COUNT[WIDTH-1:0];
  localparam bit               c_SAT     = (SATURATE == COUNT_SATURATE);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             terminal_q;
  logic             terminal_d;
  logic             overflow_q;
  logic             overflow_d;

  logic             w_tick;
  logic             w_limit;
  logic [WIDTH:0]   w_count_ext;
  logic [WIDTH:0]   w_load_ext;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .clear  (load),
    .tick   (w_tick)
  );

  assign w_count_ext = {1'b0, count_q};
  assign w_load_ext  = {1'b0, load_value};

  always_comb begin
    count_d = count_q;
    w_limit = 1'b0;
    if (load) begin
      count_d = (w_load_ext > c_MAX_EXT) ? c_MAX : load_value;
    end else if (w_tick) begin
      if (up) begin
        if (w_count_ext < c_MAX_EXT) begin
          count_d = count_q + 1'b1;
        end else begin
          w_limit = 1'b1;
          count_d = c_SAT ? c_MAX : '0;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          w_limit = 1'b1;
          count_d = c_SAT ? '0 : c_MAX;
        end
      end
    end
    terminal_d = w_limit;
    // A limit event in the same cycle as clear_flag keeps the flag set.
    overflow_d = w_limit | (overflow_q & ~clear_flag);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q    <= '0;
      terminal_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      terminal_q <= terminal_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign terminal = terminal_q;
  assign overflow = overflow_q;
  assign at_zero  = (count_q == '0);
  assign at_max   = (count_q == c_MAX);

endmodule : up_down_counter_n

`default_nettype wire

// File: tb/tb_up_down_counter_n.sv
// ---------------------------------------------------------------------------
// tb_up_down_counter_n - directed plus random checks of six counter configs
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_up_down_counter_n;

  localparam int NI = 6;

  localparam longint M_MAX [NI] = '{15, 9, 9, 9, 64'hFFFF_FFFF, 5};
  localparam int     M_PS  [NI] = '{1, 1, 1, 3, 1, 5};
  localparam bit     M_SAT [NI] = '{0, 0, 1, 0, 0, 1};
  localparam int     M_W   [NI] = '{4, 4, 4, 4, 32, 3};

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        up    = 1'b0;
  logic        ld    = 1'b0;
  logic        clr   = 1'b0;
  logic [31:0] lv32  = '0;

  logic [3:0]  c0, c1, c2, c3;
  logic [31:0] c4;
  logic [2:0]  c5;
  logic [NI-1:0] o_term, o_ovf, o_az, o_am;
  longint      o_cnt [NI];

  longint      m_cnt  [NI];
  int          m_pre  [NI];
  bit          m_term [NI];
  bit          m_ovf  [NI];

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  up_down_counter_n #(.WIDTH(4), .PRESCALE(1), .SATURATE(0)) dut0 (
    .clock(clock), .reset(rst_n), .enable(en), .up(up), .load(ld), .load_value(lv32[3:0]),
    .clear_flag(clr), .count(c0), .terminal(o_term[0]), .overflow(o_ovf[0]),
    .at_zero(o_az[0]), .at_max(o_am[0]));
  up_down_counter_n #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(0)) dut1 (
    .clock(clock), .reset(rst_n), .enable(en), .up(up), .load(ld), .load_value(lv32[3:0]),
    .clear_flag(clr), .count(c1), .terminal(o_term[1]), .overflow(o_ovf[1]),
    .at_zero(o_az[1]), .at_max(o_am[1]));
  up_down_counter_n #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(1)) dut2 (
    .clock(clock), .reset(rst_n), .enable(en), .up(up), .load(ld), .load_value(lv32[3:0]),
    .clear_flag(clr), .count(c2), .terminal(o_term[2]), .overflow(o_ovf[2]),
    .at_zero(o_az[2]), .at_max(o_am[2]));
  up_down_counter_n #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(3), .SATURATE(0)) dut3 (
    .clock(clock), .reset(rst_n), .enable(en), .up(up), .load(ld), .load_value(lv32[3:0]),
    .clear_flag(clr), .count(c3), .terminal(o_term[3]), .overflow(o_ovf[3]),
    .at_zero(o_az[3]), .at_max(o_am[3]));
  up_down_counter_n #(.WIDTH(32), .PRESCALE(1), .SATURATE(0)) dut4 (
    .clock(clock), .reset(rst_n), .enable(en), .up(up), .load(ld), .load_value(lv32),
    .clear_flag(clr), .count(c4), .terminal(o_term[4]), .overflow(o_ovf[4]),
    .at_zero(o_az[4]), .at_max(o_am[4]));
  up_down_counter_n #(.WIDTH(3), .MAX_COUNT(5), .PRESCALE(5), .SATURATE(1)) dut5 (
    .clock(clock), .reset(rst_n), .enable(en), .up(up), .load(ld), .load_value(lv32[2:0]),
    .clear_flag(clr), .count(c5), .terminal(o_term[5]), .overflow(o_ovf[5]),
    .at_zero(o_az[5]), .at_max(o_am[5]));

  always_comb begin
    o_cnt[0] = longint'(c0);
    o_cnt[1] = longint'(c1);
    o_cnt[2] = longint'(c2);
    o_cnt[3] = longint'(c3);
    o_cnt[4] = longint'(c4);
    o_cnt[5] = longint'(c5);
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: advance every configuration by one clock edge from the rules.
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      longint lv;
      bit     tick;
      bit     lim;
      lv = longint'(lv32) & ((64'd1 << M_W[i]) - 64'd1);
      if (!rst_n) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_term[i] = 0; m_ovf[i] = 0;
      end else if (ld) begin
        m_cnt[i]  = (lv > M_MAX[i]) ? M_MAX[i] : lv;
        m_pre[i]  = 0;
        m_term[i] = 0;
        m_ovf[i]  = m_ovf[i] && !clr;
      end else begin
        tick = en && (m_pre[i] == M_PS[i] - 1);
        if (en) m_pre[i] = tick ? 0 : m_pre[i] + 1;
        lim = 0;
        if (tick) begin
          if (up) begin
            if (m_cnt[i] < M_MAX[i]) m_cnt[i] = m_cnt[i] + 1;
            else begin lim = 1; m_cnt[i] = M_SAT[i] ? M_MAX[i] : 0; end
          end else begin
            if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            else begin lim = 1; m_cnt[i] = M_SAT[i] ? 0 : M_MAX[i]; end
          end
        end
        m_term[i] = lim;
        m_ovf[i]  = lim || (m_ovf[i] && !clr);
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_val($sformatf("%s_cnt%0d", tag, i), o_cnt[i], m_cnt[i]);
      check_val($sformatf("%s_term%0d", tag, i), longint'(o_term[i]), longint'(m_term[i]));
      check_val($sformatf("%s_ovf%0d", tag, i), longint'(o_ovf[i]), longint'(m_ovf[i]));
      check_val($sformatf("%s_az%0d", tag, i), longint'(o_az[i]), longint'(m_cnt[i] == 0));
      check_val($sformatf("%s_am%0d", tag, i), longint'(o_am[i]), longint'(m_cnt[i] == M_MAX[i]));
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clock);
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input bit r, input bit e, input bit u, input bit l, input bit c,
                       input logic [31:0] v);
    rst_n = r; en = e; up = u; ld = l; clr = c; lv32 = v;
  endtask

  initial begin
    #2;
    drive(0, 0, 0, 0, 0, 0);
    cycle("rst");

    // Wrap up through full 4-bit range.
    drive(1, 1, 1, 0, 0, 0);
    for (int k = 0; k < 16; k++) cycle("t1");
    check_val("t1_wrap_cnt", o_cnt[0], 0);
    check_val("t1_wrap_term", longint'(o_term[0]), 1);
    check_val("t1_wrap_ovf", longint'(o_ovf[0]), 1);
    cycle("t1b");
    check_val("t1_term_drop", longint'(o_term[0]), 0);

    // Decade counter counting down from reset.
    drive(0, 0, 0, 0, 0, 0);
    cycle("t2r");
    drive(1, 1, 0, 0, 0, 0);
    cycle("t2");
    check_val("t2_down_wrap", o_cnt[1], 9);
    check_val("t2_down_term", longint'(o_term[1]), 1);
    drive(1, 1, 0, 0, 1, 0);
    cycle("t2c");
    check_val("t2_clr_ovf", longint'(o_ovf[1]), 0);
    check_val("t2_down8", o_cnt[1], 8);

    // Saturating hold at the top, clear colliding with a limit event.
    drive(1, 1, 1, 1, 0, 7);
    cycle("t3l");
    drive(1, 1, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle("t3");
    drive(1, 1, 1, 0, 1, 0);
    cycle("t3c");
    check_val("t3_sat_cnt", o_cnt[2], 9);
    check_val("t3_sat_term", longint'(o_term[2]), 1);
    check_val("t3_set_wins", longint'(o_ovf[2]), 1);

    // Prescale of three with enable gaps.
    drive(0, 0, 0, 0, 0, 0);
    cycle("t4r");
    drive(1, 1, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) cycle("t4");
    check_val("t4_ps_cnt", o_cnt[3], 2);
    cycle("t4a");
    drive(1, 0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle("t4g");
    drive(1, 1, 1, 0, 0, 0);
    cycle("t4b");
    check_val("t4_frozen", o_cnt[3], 2);
    cycle("t4s");
    check_val("t4_resume", o_cnt[3], 3);

    // Load clamps and beats a coincident tick, clearing the prescaler.
    cycle("t5a");
    cycle("t5b");
    drive(1, 1, 1, 1, 0, 12);
    cycle("t5l");
    check_val("t5_clamp", o_cnt[3], 9);
    check_val("t5_no_term", longint'(o_term[3]), 0);
    drive(1, 1, 1, 0, 0, 0);
    cycle("t5c");
    cycle("t5d");
    check_val("t5_ps_cleared", o_cnt[3], 9);
    cycle("t5e");
    check_val("t5_wrap", o_cnt[3], 0);

    // Reset mid-prescale overrides load and enable.
    drive(1, 1, 1, 1, 0, 5);
    cycle("t6l");
    drive(1, 1, 1, 0, 0, 0);
    cycle("t6p");
    drive(0, 1, 1, 1, 0, 5);
    cycle("t6r");
    check_val("t6_rst_cnt", o_cnt[3], 0);
    check_val("t6_rst_ovf", longint'(o_ovf[3]), 0);
    drive(1, 1, 1, 0, 0, 0);
    cycle("t6a");
    cycle("t6b");
    check_val("t6_full_period", o_cnt[3], 0);
    cycle("t6c");
    check_val("t6_resumed", o_cnt[3], 1);

    // 32-bit counter at the top of its range.
    drive(1, 1, 1, 1, 0, 32'hFFFF_FFFF);
    cycle("w32l");
    check_val("w32_load", o_cnt[4], 64'hFFFF_FFFF);
    drive(1, 1, 1, 0, 0, 0);
    cycle("w32s");
    check_val("w32_wrap", o_cnt[4], 0);
    check_val("w32_term", longint'(o_term[4]), 1);

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      logic [31:0] v;
      case ($urandom_range(0, 3))
        0:       v = 32'hFFFF_FFFF;
        1:       v = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        2:       v = $urandom;
        default: v = $urandom_range(0, 15);
      endcase
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), v);
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_up_down_counter_n

`default_nettype wire
